// File: rtl/io_bus_pkg.sv
// Shared definitions for the memory-mapped IO controller: register map
// and the switch-to-nibble encoder used by hex entry.
package io_bus_pkg;

    localparam logic [7:0] IO_LED  = 8'h00;
    localparam logic [7:0] IO_SEG  = 8'h04;
    localparam logic [7:0] IO_SW   = 8'h08;
    localparam logic [7:0] IO_VLD  = 8'h0C;
    localparam logic [7:0] IO_DATA = 8'h10;
    localparam logic [7:0] IO_RDY  = 8'h14;

    // Index of the lowest set bit; several simultaneous rises collapse to one nibble.
    function automatic logic [3:0] nibble_of_lowest(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer followed by an optional per-bit debounce counter.
// Macro IO_DEBOUNCE_EN enables the counter stage; without it the debounced
// value is the synchronizer output and DB_CYCLES has no effect.
module io_debounce #(
    parameter int WIDTH     = 17,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] db
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // Bring the asynchronous board inputs into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= raw;
            sync_reg <= meta_reg;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_reg;
            logic             db_reg;

            // Accept a new level only after it has differed for DB_CYCLES consecutive cycles.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                    db_reg  <= 1'b0;
                end else if (sync_reg[gi] == db_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
                    cnt_reg <= '0;
                    db_reg  <= sync_reg[gi];
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign db[gi] = db_reg;
        end
    endgenerate
`else
    assign db = sync_reg;
`endif

endmodule

// File: rtl/io_bus_ctrl.sv
// IO controller on the CPU's memory-mapped IO bus: LED register, scanned
// 8-digit hex display with a busy/ready handshake, and handshaked hex entry
// from switches plus commit button. Optional macro: IO_DEBOUNCE_EN.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000,
    parameter int SCAN_DIV  = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    output logic [31:0] io_din,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [15:0] led,
    output logic [2:0]  an,
    output logic [3:0]  seg_d
);

    localparam int DIV_W   = $clog2(SCAN_DIV + 1);
    localparam int FRAME_W = $clog2(8 * SCAN_DIV + 1);

    logic [16:0]        db_in;
    logic [16:0]        db_prev_reg;
    logic [16:0]        rise;
    logic [15:0]        led_reg;
    logic [31:0]        seg_data_reg;
    logic [31:0]        in_data_reg;
    logic               in_vld_reg;
    logic               out_rdy_reg;
    logic [DIV_W-1:0]   div_reg;
    logic [2:0]         an_reg;
    logic [FRAME_W-1:0] frame_reg;
    logic               wr_led;
    logic               wr_seg;
    logic               ack;

    io_debounce #(
        .WIDTH     (17),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk (clk),
        .rst (rst),
        .raw ({btn, sw}),
        .db  (db_in)
    );

    assign rise   = db_in & ~db_prev_reg;
    assign wr_led = io_we && (io_addr == IO_LED);
    assign wr_seg = io_we && (io_addr == IO_SEG) && out_rdy_reg;
    assign ack    = io_we && (io_addr == IO_VLD);

    // Edge history for the debounced inputs and the LED register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_prev_reg <= '0;
            led_reg     <= '0;
        end else begin
            db_prev_reg <= db_in;
            if (wr_led) led_reg <= io_dout[15:0];
        end
    end

    // Hex entry: ack clears first, a button rise then sets valid, so set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_data_reg <= '0;
            in_vld_reg  <= 1'b0;
        end else begin
            if (ack) begin
                in_data_reg <= '0;
                in_vld_reg  <= 1'b0;
            end else if (!in_vld_reg && (|rise[15:0])) begin
                in_data_reg <= {in_data_reg[27:0], nibble_of_lowest(rise[15:0])};
            end
            if (rise[16]) in_vld_reg <= 1'b1;
        end
    end

    // Free-running digit scan: divider wraps every SCAN_DIV cycles and steps the digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg <= '0;
            an_reg  <= '0;
        end else if (div_reg == DIV_W'(SCAN_DIV - 1)) begin
            div_reg <= '0;
            an_reg  <= an_reg + 1'b1;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    // Display handshake: an accepted frame holds off new data for one full refresh.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_data_reg <= '0;
            out_rdy_reg  <= 1'b1;
            frame_reg    <= '0;
        end else if (wr_seg) begin
            seg_data_reg <= io_dout;
            out_rdy_reg  <= 1'b0;
            frame_reg    <= '0;
        end else if (!out_rdy_reg) begin
            if (frame_reg == FRAME_W'(8 * SCAN_DIV - 1)) begin
                out_rdy_reg <= 1'b1;
                frame_reg   <= '0;
            end else begin
                frame_reg <= frame_reg + 1'b1;
            end
        end
    end

    // Read mux, combinational on the address; unmapped addresses read as zero.
    always_comb begin
        io_din = '0;
        case (io_addr)
            IO_LED:  io_din = {16'b0, led_reg};
            IO_SW:   io_din = {16'b0, db_in[15:0]};
            IO_VLD:  io_din = {31'b0, in_vld_reg};
            IO_DATA: io_din = in_data_reg;
            IO_RDY:  io_din = {31'b0, out_rdy_reg};
            default: io_din = '0;
        endcase
    end

    assign led   = led_reg;
    assign an    = an_reg;
    assign seg_d = seg_data_reg[{an_reg, 2'b00} +: 4];

endmodule
